// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the memory-mapped UART: register offsets (as seen
// on uart_addr[3:2]), bit positions inside the STATUS register, and the
// state encodings of the transmit and receive state machines.
package uart_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_RXDATA = 2'd1;
   localparam logic [1:0] OFF_STATUS = 2'd2;
   localparam logic [1:0] OFF_DIV    = 2'd3;

   localparam int ST_TX_BUSY    = 0;
   localparam int ST_TX_FULL    = 1;
   localparam int ST_RX_VALID   = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_FRAME_ERR  = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Small synchronous FIFO that buffers bytes waiting to be transmitted.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, din    write side; a push into a full FIFO is dropped unless a
//                pop happens in the same cycle
//   pop, dout    read side; dout shows the oldest entry (first-word fall-through)
//   count        number of stored entries (0..DEPTH)
//   full, empty  occupancy flags
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio
// Memory-mapped 8N1 UART responder for the bus UART window.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   uart_addr         bus address, bits [3:2] select TXDATA/RXDATA/STATUS/DIV
//   uart_write_data   write data
//   uart_wen          write strobe, already qualified by the UART window
//   uart_read_data    combinational register read data
//   tx, rx            serial out (idle high) and asynchronous serial in
//   irq               level interrupt: rx_valid | rx_overrun | frame_err
module uart_mmio
   import uart_pkg::*;
#(
   parameter int          TX_DEPTH  = 4,
   parameter logic [15:0] DIV_RESET = 16'd867
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] uart_addr,
   input  logic [31:0] uart_write_data,
   input  logic        uart_wen,
   output logic [31:0] uart_read_data,
   output logic        tx,
   input  logic        rx,
   output logic        irq
);

   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic [1:0]    sel;
   logic          wr_txdata, wr_rxdata, wr_status, wr_div;
   logic [15:0]   div;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty, tx_pop;
   logic          tx_busy, tx_full;
   tx_state_e     tx_state;
   logic [15:0]   tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          rx_meta, rx_sync;
   rx_state_e     rx_state;
   logic [15:0]   rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic [16:0]   div_plus_one;
   logic [15:0]   half_wait;
   logic          rx_done, stop_ok, stop_bad, rx_valid_keep;
   logic          rx_valid, rx_overrun, frame_err;
   logic [7:0]    rx_byte;
   logic          unused_bits;

   assign sel       = uart_addr[3:2];
   assign wr_txdata = uart_wen && (sel == OFF_TXDATA);
   assign wr_rxdata = uart_wen && (sel == OFF_RXDATA);
   assign wr_status = uart_wen && (sel == OFF_STATUS);
   assign wr_div    = uart_wen && (sel == OFF_DIV);

   assign unused_bits = ^{uart_addr[63:4], uart_addr[1:0], uart_write_data[31:16], fifo_full};

   uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_txdata),
      .din   (uart_write_data[7:0]),
      .pop   (tx_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tx_full = (fifo_count == CW'(TX_DEPTH));
   assign tx_busy = (tx_state != TX_IDLE) | ~fifo_empty;
   assign irq     = rx_valid | rx_overrun | frame_err;

   // A byte leaves the FIFO whenever a new frame starts: from idle, or
   // straight out of a finished stop bit so frames run back-to-back.
   always_comb begin
      tx_pop = 1'b0;
      if (!fifo_empty) begin
         if (tx_state == TX_IDLE) tx_pop = 1'b1;
         if (tx_state == TX_STOP && tx_cnt == '0) tx_pop = 1'b1;
      end
   end

   // Transmit state machine; each bit lasts DIV+1 cycles, with DIV reloaded
   // at every bit start so a DIV change only affects later bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (!fifo_empty) begin
                  tx_state <= TX_START;
                  tx_shift <= fifo_dout;
                  tx_cnt   <= div;
                  tx       <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt == '0) begin
                  tx_state <= TX_DATA;
                  tx_bit   <= '0;
                  tx_cnt   <= div;
                  tx       <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == '0) begin
                  tx_cnt <= div;
                  if (tx_bit == 3'd7) begin
                     tx_state <= TX_STOP;
                     tx       <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx       <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == '0) begin
                  if (!fifo_empty) begin
                     tx_state <= TX_START;
                     tx_shift <= fifo_dout;
                     tx_cnt   <= div;
                     tx       <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous serial input, idling high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // The start bit is re-checked (DIV+1)/2 cycles after it is seen; the
   // counter is loaded with one less because the check edge itself counts.
   assign div_plus_one = {1'b0, div} + 17'd1;
   assign half_wait    = (div_plus_one[16:1] == '0) ? 16'd0 : div_plus_one[16:1] - 16'd1;
   assign rx_done      = (rx_state == RX_STOP) && (rx_cnt == '0);
   assign stop_ok      = rx_done & rx_sync;
   assign stop_bad     = rx_done & ~rx_sync;

   // Receive state machine: start check at mid-bit, then 8 data samples and
   // the stop sample spaced one bit period apart, LSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  rx_state <= RX_START;
                  rx_cnt   <= half_wait;
               end
            end
            RX_START: begin
               if (rx_cnt == '0) begin
                  if (!rx_sync) begin
                     rx_state <= RX_DATA;
                     rx_bit   <= '0;
                     rx_cnt   <= div;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == '0) begin
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_cnt   <= div;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == '0) rx_state <= RX_IDLE;
               else              rx_cnt   <= rx_cnt - 16'd1;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // A completion that coincides with an RXDATA acknowledge is treated as
   // landing in an empty holding register, so it is kept and not an overrun.
   assign rx_valid_keep = rx_valid & ~wr_rxdata;

   // Software-visible registers; a newly detected error beats its clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div        <= DIV_RESET;
         rx_valid   <= 1'b0;
         rx_byte    <= '0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (wr_div) div <= uart_write_data[15:0];
         if (stop_ok && !rx_valid_keep) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
         end else if (wr_rxdata) begin
            rx_valid <= 1'b0;
         end
         if (stop_ok && rx_valid_keep)
            rx_overrun <= 1'b1;
         else if (wr_status && uart_write_data[ST_RX_OVERRUN])
            rx_overrun <= 1'b0;
         if (stop_bad)
            frame_err <= 1'b1;
         else if (wr_status && uart_write_data[ST_FRAME_ERR])
            frame_err <= 1'b0;
      end
   end

   // Zero-latency read mux straight off the registers.
   always_comb begin
      uart_read_data = '0;
      case (sel)
         OFF_RXDATA: uart_read_data = {23'b0, rx_valid, rx_byte};
         OFF_STATUS: begin
            uart_read_data[ST_TX_BUSY]    = tx_busy;
            uart_read_data[ST_TX_FULL]    = tx_full;
            uart_read_data[ST_RX_VALID]   = rx_valid;
            uart_read_data[ST_RX_OVERRUN] = rx_overrun;
            uart_read_data[ST_FRAME_ERR]  = frame_err;
         end
         OFF_DIV:    uart_read_data = {16'b0, div};
         default:    uart_read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio
// Directed bench for uart_mmio: register access, TX framing and FIFO
// behaviour, RX reception with overrun/framing errors, glitch rejection and
// reset in the middle of a transmitted frame. Expected TX bytes go into a
// scoreboard queue as they are written and are popped by a serial monitor.
module tb_uart_mmio;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] uart_addr = '0;
   logic [31:0] uart_write_data = '0;
   logic        uart_wen = 1'b0;
   logic        rx = 1'b1;
   logic [31:0] uart_read_data;
   logic        tx;
   logic        irq;

   int          checks = 0;
   int          errors = 0;
   int          bit_len = 868;
   bit          mon_en = 1'b1;
   logic [7:0]  tx_sb[$];
   logic [7:0]  rx_sb[$];

   uart_mmio #(.TX_DEPTH(4), .DIV_RESET(16'd867)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .uart_addr       (uart_addr),
      .uart_write_data (uart_write_data),
      .uart_wen        (uart_wen),
      .uart_read_data  (uart_read_data),
      .tx              (tx),
      .rx              (rx),
      .irq             (irq)
   );

   // 100 MHz system clock.
   always #5 clk = ~clk;

   // Every comparison goes through here so the counters stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle register write; called at a negedge, returns at the next one.
   task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
      uart_addr       = {60'b0, addr};
      uart_write_data = data;
      uart_wen        = 1'b1;
      @(negedge clk);
      uart_wen        = 1'b0;
   endtask

   // Combinational register read compared against an expected value.
   task automatic readReg(input logic [3:0] addr, input string tag, input logic [31:0] expected);
      uart_addr = {60'b0, addr};
      #1;
      checkOutput(tag, uart_read_data, expected);
   endtask

   // Drive one serial frame on rx, bit_len cycles per bit, LSB first.
   task automatic sendFrame(input logic [7:0] data, input logic stop_bit);
      rx = 1'b0;
      repeat (bit_len) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (bit_len) @(negedge clk);
      end
      rx = stop_bit;
      repeat (bit_len) @(negedge clk);
      rx = 1'b1;
   endtask

   // Serial monitor: decodes each tx frame at mid-bit and checks it
   // against the oldest scoreboard entry.
   initial begin
      logic [7:0] got;
      logic       stop_seen;
      logic [8:0] exp_byte;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && tx === 1'b0) begin
            aborted = 1'b0;
            repeat (bit_len / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (bit_len) @(negedge clk);
               if (!rst_n) aborted = 1'b1;
               got[i] = tx;
            end
            repeat (bit_len) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            stop_seen = tx;
            if (!aborted) begin
               exp_byte = (tx_sb.size() != 0) ? {1'b0, tx_sb.pop_front()} : 9'h1FF;
               checkOutput("tx_frame_byte", {23'b0, 1'b0, got}, {23'b0, exp_byte});
               checkOutput("tx_stop_bit", {31'b0, stop_seen}, 32'd1);
            end
         end
      end
   end

   initial begin
      int         cycles;
      logic [7:0] exp_rx;

      $display("[TB] reset state");
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_tx", {31'b0, tx}, 32'd1);
      checkOutput("rst_irq", {31'b0, irq}, 32'd0);
      readReg(4'hC, "rst_div", 32'd867);
      readReg(4'h8, "rst_status", 32'h0);
      readReg(4'h4, "rst_rxdata", 32'h0);
      readReg(4'h0, "rst_txdata_read", 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] single TX frame 0x55");
      applyStimulus(4'hC, 32'd3);
      bit_len = 4;
      readReg(4'hC, "div_rw", 32'd3);
      @(negedge clk);
      tx_sb.push_back(8'h55);
      applyStimulus(4'h0, 32'h55);
      checkOutput("t1_tx_high_at_write", {31'b0, tx}, 32'd1);
      readReg(4'h8, "t1_busy_queued", 32'h1);
      @(negedge clk);
      checkOutput("t1_start_low", {31'b0, tx}, 32'd0);
      repeat (39) @(negedge clk);
      readReg(4'h8, "t1_busy_in_stop", 32'h1);
      @(negedge clk);
      readReg(4'h8, "t1_busy_drop", 32'h0);
      checkOutput("t1_tx_idle", {31'b0, tx}, 32'd1);
      repeat (3) @(negedge clk);

      $display("[TB] FIFO fill with one dropped write");
      for (int i = 0; i < 6; i++) begin
         if (i < 5) tx_sb.push_back(8'hA1 + 8'(i));
         applyStimulus(4'h0, 32'hA1 + i);
      end
      readReg(4'h8, "t2_full", 32'h3);
      cycles = 0;
      uart_addr = 64'h8;
      #1;
      while (uart_read_data[0] && cycles < 2000) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("t2_drain_cycles", cycles, 32'd196);
      checkOutput("t2_sb_drained", tx_sb.size(), 32'd0);
      repeat (3) @(negedge clk);

      $display("[TB] RX byte 0xA3");
      rx_sb.push_back(8'hA3);
      sendFrame(8'hA3, 1'b1);
      repeat (3) @(negedge clk);
      exp_rx = rx_sb.pop_front();
      readReg(4'h4, "t3_rxdata", {23'b0, 1'b1, exp_rx});
      checkOutput("t3_irq_set", {31'b0, irq}, 32'd1);
      @(negedge clk);
      applyStimulus(4'h4, 32'h0);
      readReg(4'h4, "t3_rxdata_ack", {24'b0, exp_rx});
      checkOutput("t3_irq_clear", {31'b0, irq}, 32'd0);
      @(negedge clk);

      $display("[TB] overrun and framing error");
      rx_sb.push_back(8'h11);
      sendFrame(8'h11, 1'b1);
      sendFrame(8'h22, 1'b1);
      repeat (3) @(negedge clk);
      exp_rx = rx_sb.pop_front();
      readReg(4'h4, "t4_rx_keeps_first", {23'b0, 1'b1, exp_rx});
      readReg(4'h8, "t4_overrun", 32'h0C);
      @(negedge clk);
      sendFrame(8'h5A, 1'b0);
      repeat (60) @(negedge clk);
      readReg(4'h8, "t4_frame_err", 32'h1C);
      @(negedge clk);
      applyStimulus(4'h8, 32'h18);
      readReg(4'h8, "t4_flags_cleared", 32'h04);
      checkOutput("t4_irq_valid_only", {31'b0, irq}, 32'd1);
      @(negedge clk);
      applyStimulus(4'h4, 32'h0);
      checkOutput("t4_irq_clear", {31'b0, irq}, 32'd0);
      @(negedge clk);

      $display("[TB] rx glitch rejection");
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      readReg(4'h8, "t5_glitch_status", 32'h0);
      readReg(4'h4, "t5_glitch_rxdata", {24'b0, exp_rx});
      checkOutput("t5_glitch_irq", {31'b0, irq}, 32'd0);
      @(negedge clk);

      $display("[TB] reset during a TX frame");
      mon_en = 1'b0;
      applyStimulus(4'h0, 32'hF0);
      repeat (10) @(negedge clk);
      checkOutput("t5_tx_mid_frame", {31'b0, tx}, 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_tx_high", {31'b0, tx}, 32'd1);
      checkOutput("t5_rst_irq", {31'b0, irq}, 32'd0);
      readReg(4'h8, "t5_rst_status", 32'h0);
      readReg(4'hC, "t5_rst_div", 32'd867);
      readReg(4'h4, "t5_rst_rxdata", 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("t5_post_rst_tx", {31'b0, tx}, 32'd1);
      readReg(4'h8, "t5_post_rst_status", 32'h0);

      checkOutput("final_sb_empty", tx_sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
